// File: rtl/urv_dm_arbiter.sv
// Shares the data-memory port between the core X-stage (c_*) and a host/debug port (h_*).
// Core has priority, host starvation is bounded, and a timeout aborts hung accesses.
module urv_dm_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter int unsigned CORE_MAX_CONSEC = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_s_i,
    input  logic [3:0]  c_select_i,
    input  logic        c_load_i,
    input  logic        c_store_i,
    output logic        c_ready_o,
    output logic        c_err_o,
    output logic [31:0] c_data_l_o,

    input  logic [31:0] h_addr_i,
    input  logic [31:0] h_data_s_i,
    input  logic [3:0]  h_select_i,
    input  logic        h_load_i,
    input  logic        h_store_i,
    output logic        h_ready_o,
    output logic        h_err_o,
    output logic [31:0] h_data_l_o,

    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_s_o,
    output logic [3:0]  m_select_o,
    output logic        m_load_o,
    output logic        m_store_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_data_l_i,

    output logic        busy_o,
    output logic        grant_host_o
);
    localparam int unsigned TMO_W = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_C = 2'd1;
    localparam logic [1:0] ST_BUSY_H = 2'd2;

    // The abort fires in the TIMEOUT_CYCLES-th BUSY cycle, i.e. when the count is one short.
    localparam bit               TMO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONSEC_MAX = CNT_W'(CORE_MAX_CONSEC);

    logic [1:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       sel_q, sel_d;
    logic             load_q, load_d;
    logic             store_q, store_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ghost_q, ghost_d;
    logic             busy_q;

    logic c_req, h_req, in_busy, tmo_hit, done, core_wins;

    assign c_req     = c_load_i | c_store_i;
    assign h_req     = h_load_i | h_store_i;
    assign in_busy   = (state_q == ST_BUSY_C) || (state_q == ST_BUSY_H);
    assign tmo_hit   = TMO_EN && in_busy && !m_ready_i && (tmo_q == TMO_LAST);
    assign done      = in_busy && (m_ready_i || tmo_hit);
    assign core_wins = c_req && !(h_req && (consec_q == CONSEC_MAX));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            consec_q <= '0;
            tmo_q    <= '0;
            ghost_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            load_q   <= load_d;
            store_q  <= store_d;
            consec_q <= consec_d;
            tmo_q    <= tmo_d;
            ghost_q  <= ghost_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Grant selection in IDLE; hold the access stable until completion or abort.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        load_d   = load_q;
        store_d  = store_q;
        consec_d = consec_q;
        tmo_d    = tmo_q;
        ghost_d  = ghost_q;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (!h_req) consec_d = '0;
                if (core_wins) begin
                    state_d = ST_BUSY_C;
                    addr_d  = c_addr_i;
                    wdata_d = c_data_s_i;
                    sel_d   = c_select_i;
                    store_d = c_store_i;
                    load_d  = c_load_i & ~c_store_i;
                    ghost_d = 1'b0;
                    if (h_req) consec_d = consec_q + CNT_W'(1);
                end else if (h_req) begin
                    state_d  = ST_BUSY_H;
                    addr_d   = h_addr_i;
                    wdata_d  = h_data_s_i;
                    sel_d    = h_select_i;
                    store_d  = h_store_i;
                    load_d   = h_load_i & ~h_store_i;
                    ghost_d  = 1'b1;
                    consec_d = '0;
                end
            end
            ST_BUSY_C, ST_BUSY_H: begin
                if (done) begin
                    state_d = ST_IDLE;
                    load_d  = 1'b0;
                    store_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                load_d  = 1'b0;
                store_d = 1'b0;
            end
        endcase
    end

    assign m_addr_o     = addr_q;
    assign m_data_s_o   = wdata_q;
    assign m_select_o   = sel_q;
    assign m_load_o     = load_q;
    assign m_store_o    = store_q;
    assign busy_o       = busy_q;
    assign grant_host_o = ghost_q;

    // Completion is reported in the same cycle as m_ready_i or the abort.
    assign c_ready_o  = done && (state_q == ST_BUSY_C);
    assign h_ready_o  = done && (state_q == ST_BUSY_H);
    assign c_err_o    = tmo_hit && (state_q == ST_BUSY_C);
    assign h_err_o    = tmo_hit && (state_q == ST_BUSY_H);
    assign c_data_l_o = ((state_q == ST_BUSY_C) && m_ready_i) ? m_data_l_i : 32'h0;
    assign h_data_l_o = ((state_q == ST_BUSY_H) && m_ready_i) ? m_data_l_i : 32'h0;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Bench for urv_dm_arbiter: directed scenarios plus random traffic, all cycles checked
// against a transaction-level reference model.
module tb_urv_dm_arbiter;
    localparam int unsigned TMO  = 8;
    localparam int unsigned MAXC = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] c_addr_i, c_data_s_i, h_addr_i, h_data_s_i, m_data_l_i;
    logic [3:0]  c_select_i, h_select_i;
    logic        c_load_i, c_store_i, h_load_i, h_store_i, m_ready_i;
    logic        c_ready_o, c_err_o, h_ready_o, h_err_o;
    logic [31:0] c_data_l_o, h_data_l_o, m_addr_o, m_data_s_o;
    logic [3:0]  m_select_o;
    logic        m_load_o, m_store_o, busy_o, grant_host_o;

    urv_dm_arbiter #(.TIMEOUT_CYCLES(TMO), .CORE_MAX_CONSEC(MAXC)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .c_addr_i(c_addr_i), .c_data_s_i(c_data_s_i), .c_select_i(c_select_i),
        .c_load_i(c_load_i), .c_store_i(c_store_i),
        .c_ready_o(c_ready_o), .c_err_o(c_err_o), .c_data_l_o(c_data_l_o),
        .h_addr_i(h_addr_i), .h_data_s_i(h_data_s_i), .h_select_i(h_select_i),
        .h_load_i(h_load_i), .h_store_i(h_store_i),
        .h_ready_o(h_ready_o), .h_err_o(h_err_o), .h_data_l_o(h_data_l_o),
        .m_addr_o(m_addr_o), .m_data_s_o(m_data_s_o), .m_select_o(m_select_o),
        .m_load_o(m_load_o), .m_store_o(m_store_o),
        .m_ready_i(m_ready_i), .m_data_l_i(m_data_l_i),
        .busy_o(busy_o), .grant_host_o(grant_host_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: owner 0 none / 1 core / 2 host, age = BUSY cycles already spent.
    int          own = 0;
    int          age = 0;
    int          streak = 0;
    logic [31:0] ma = '0, md = '0;
    logic [3:0]  ms = '0;
    bit          kst = 0;
    bit          last_h = 0;
    bit          e_c_ready = 0, e_h_ready = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic eval();
        bit tmo, fin, creq, hreq;
        @(negedge clk_i);
        tmo = (own != 0) && !m_ready_i && (TMO != 0) && (age + 1 == int'(TMO));
        fin = (own != 0) && (m_ready_i || tmo);
        e_c_ready = (own == 1) && fin;
        e_h_ready = (own == 2) && fin;
        chk("busy", 32'(busy_o), 32'(own != 0));
        chk("grant_host", 32'(grant_host_o), 32'(last_h));
        chk("m_addr", m_addr_o, ma);
        chk("m_data_s", m_data_s_o, md);
        chk("m_select", 32'(m_select_o), 32'(ms));
        chk("m_load", 32'(m_load_o), 32'((own != 0) && !kst));
        chk("m_store", 32'(m_store_o), 32'((own != 0) && kst));
        chk("c_ready", 32'(c_ready_o), 32'(e_c_ready));
        chk("h_ready", 32'(h_ready_o), 32'(e_h_ready));
        chk("c_err", 32'(c_err_o), 32'((own == 1) && tmo));
        chk("h_err", 32'(h_err_o), 32'((own == 2) && tmo));
        chk("c_data_l", c_data_l_o, ((own == 1) && m_ready_i) ? m_data_l_i : 32'h0);
        chk("h_data_l", h_data_l_o, ((own == 2) && m_ready_i) ? m_data_l_i : 32'h0);
        creq = c_load_i | c_store_i;
        hreq = h_load_i | h_store_i;
        if (!rst_n_i) begin
            own = 0; age = 0; streak = 0; ma = '0; md = '0; ms = '0; kst = 0; last_h = 0;
        end else if (own != 0) begin
            if (fin) own = 0;
            else age++;
        end else if (creq && !(hreq && streak == int'(MAXC))) begin
            own = 1; age = 0; last_h = 0;
            ma = c_addr_i; md = c_data_s_i; ms = c_select_i; kst = c_store_i;
            streak = hreq ? streak + 1 : 0;
        end else if (hreq) begin
            own = 2; age = 0; last_h = 1; streak = 0;
            ma = h_addr_i; md = h_data_s_i; ms = h_select_i; kst = h_store_i;
        end else begin
            streak = 0;
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic new_core();
        int k;
        k = $urandom_range(0, 2);
        c_addr_i = $urandom; c_data_s_i = $urandom; c_select_i = 4'($urandom);
        c_load_i = (k != 1); c_store_i = (k != 0);
    endtask

    task automatic new_host();
        int k;
        k = $urandom_range(0, 2);
        h_addr_i = $urandom; h_data_s_i = $urandom; h_select_i = 4'($urandom);
        h_load_i = (k != 1); h_store_i = (k != 0);
    endtask

    initial begin
        logic [5:0] exp_pat;
        logic [7:0] grants;
        int         ng;
        bit         prev_busy;

        rst_n_i = 1'b0;
        c_addr_i = '0; c_data_s_i = '0; c_select_i = '0; c_load_i = 0; c_store_i = 0;
        h_addr_i = '0; h_data_s_i = '0; h_select_i = '0; h_load_i = 0; h_store_i = 0;
        m_ready_i = 0; m_data_l_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        eval();
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_m_addr", m_addr_o, 32'h0);
        chk("rst_grant", 32'(grant_host_o), 32'h0);
        adv();

        // Core load at 0x100, memory answers two cycles after the strobe.
        c_load_i = 1; c_addr_i = 32'h100; c_select_i = 4'hF;
        eval(); chk("t1_no_strobe_yet", 32'(m_load_o), 32'h0); adv();
        eval(); chk("t1_strobe", 32'(m_load_o), 32'h1); chk("t1_addr", m_addr_o, 32'h100); adv();
        eval(); chk("t1_wait", 32'(c_ready_o), 32'h0); adv();
        m_ready_i = 1; m_data_l_i = 32'hCAFEBABE;
        eval();
        chk("t1_ready", 32'(c_ready_o), 32'h1);
        chk("t1_data", c_data_l_o, 32'hCAFEBABE);
        chk("t1_strobe_last", 32'(m_load_o), 32'h1);
        adv();
        c_load_i = 0; m_ready_i = 0;
        eval(); chk("t1_idle", 32'(busy_o), 32'h0); chk("t1_strobe_drop", 32'(m_load_o), 32'h0); adv();

        // Simultaneous core store and host load: core first, host right after.
        c_store_i = 1; c_addr_i = 32'h200; c_data_s_i = 32'h1111_2222; c_select_i = 4'hF;
        h_load_i = 1; h_addr_i = 32'h300; h_select_i = 4'h3;
        eval(); adv();
        eval(); chk("t2_core_first", m_addr_o, 32'h200); chk("t2_host_waits", 32'(grant_host_o), 32'h0); adv();
        m_ready_i = 1;
        eval(); chk("t2_c_ready", 32'(c_ready_o), 32'h1); chk("t2_h_quiet", 32'(h_ready_o), 32'h0); adv();
        c_store_i = 0; m_ready_i = 0;
        eval(); adv();
        eval(); chk("t2_host_grant", 32'(grant_host_o), 32'h1); chk("t2_host_addr", m_addr_o, 32'h300); adv();
        m_ready_i = 1; m_data_l_i = 32'h0BAD_F00D;
        eval(); chk("t2_h_data", h_data_l_o, 32'h0BAD_F00D); adv();
        h_load_i = 0; m_ready_i = 0;
        eval(); adv();

        // Core continuously requesting, host waiting: four core grants, one host, core again.
        c_load_i = 1; c_addr_i = 32'hA0; h_load_i = 1; h_addr_i = 32'hB0; m_ready_i = 1;
        grants = '0; ng = 0; prev_busy = 0;
        for (int i = 0; i < 12; i++) begin
            eval();
            if (busy_o && !prev_busy && ng < 8) begin
                grants[ng] = grant_host_o;
                ng++;
            end
            prev_busy = busy_o;
            adv();
            if (e_h_ready) h_load_i = 0;
        end
        exp_pat = 6'b010000;
        chk("t3_grant_count", 32'(ng), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), 32'(grants[i]), 32'(exp_pat[i]));
        c_load_i = 0; h_load_i = 0; m_ready_i = 0;
        eval(); adv();
        eval(); adv();

        // Host store that the memory never answers.
        h_store_i = 1; h_addr_i = 32'h400; h_data_s_i = 32'hDEAD_0001; h_select_i = 4'hC;
        m_data_l_i = 32'h5555_AAAA;
        eval(); adv();
        for (int k = 1; k <= int'(TMO); k++) begin
            eval();
            if (k < int'(TMO)) begin
                chk($sformatf("t4_wait%0d", k), 32'(h_ready_o), 32'h0);
            end else begin
                chk("t4_ready", 32'(h_ready_o), 32'h1);
                chk("t4_err", 32'(h_err_o), 32'h1);
                chk("t4_data", h_data_l_o, 32'h0);
            end
            adv();
        end
        h_store_i = 0;
        eval(); chk("t4_store_low", 32'(m_store_o), 32'h0); chk("t4_idle", 32'(busy_o), 32'h0); adv();

        // Core withdraws mid-access while the host starts requesting.
        c_load_i = 1; c_addr_i = 32'h500;
        eval(); adv();
        eval(); adv();
        c_load_i = 0; h_load_i = 1; h_addr_i = 32'h600;
        eval(); chk("t5_addr_held", m_addr_o, 32'h500); chk("t5_no_host", 32'(grant_host_o), 32'h0); adv();
        eval(); chk("t5_strobe_held", 32'(m_load_o), 32'h1); adv();
        m_ready_i = 1;
        eval(); chk("t5_c_ready", 32'(c_ready_o), 32'h1); adv();
        m_ready_i = 0;
        eval(); adv();
        eval(); chk("t5_host_after", m_addr_o, 32'h600); adv();
        m_ready_i = 1;
        eval(); adv();
        h_load_i = 0; m_ready_i = 0;
        eval(); adv();

        // Reset during a host access.
        h_store_i = 1; h_addr_i = 32'h700; h_data_s_i = 32'h7777_7777; h_select_i = 4'hF;
        eval(); adv();
        eval(); adv();
        rst_n_i = 0; h_store_i = 0;
        eval(); adv();
        rst_n_i = 1; c_load_i = 1; c_addr_i = 32'h800; c_select_i = 4'h1;
        eval();
        chk("t6_busy", 32'(busy_o), 32'h0);
        chk("t6_grant", 32'(grant_host_o), 32'h0);
        chk("t6_addr", m_addr_o, 32'h0);
        chk("t6_data", m_data_s_o, 32'h0);
        chk("t6_store", 32'(m_store_o), 32'h0);
        chk("t6_h_ready", 32'(h_ready_o), 32'h0);
        adv();
        eval(); chk("t6_core_grant", m_addr_o, 32'h800); chk("t6_core_busy", 32'(busy_o), 32'h1); adv();
        m_ready_i = 1;
        eval(); adv();
        c_load_i = 0; m_ready_i = 0;
        eval(); adv();

        // Random traffic from both requesters with slow, sometimes silent memory.
        for (int i = 0; i < 3000; i++) begin
            rst_n_i = ($urandom_range(0, 299) != 0);
            if (e_c_ready) begin
                if ($urandom_range(0, 2) != 0) new_core();
                else begin c_load_i = 0; c_store_i = 0; end
            end else if (!(c_load_i | c_store_i)) begin
                if ($urandom_range(0, 1) == 0) new_core();
            end else if ($urandom_range(0, 39) == 0) begin
                c_load_i = 0; c_store_i = 0;
            end
            if (e_h_ready) begin
                if ($urandom_range(0, 2) != 0) new_host();
                else begin h_load_i = 0; h_store_i = 0; end
            end else if (!(h_load_i | h_store_i)) begin
                if ($urandom_range(0, 2) == 0) new_host();
            end else if ($urandom_range(0, 39) == 0) begin
                h_load_i = 0; h_store_i = 0;
            end
            m_ready_i = ($urandom_range(0, 3) == 0);
            m_data_l_i = $urandom;
            eval();
            chk("one_ready", 32'(c_ready_o & h_ready_o), 32'h0);
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
